sync_mode_sequencer: RTL and testbench

Self-test controller for the four-mode synchronizer (sel 0 = plain register, 1 = clk_2 register without sync, 2 = two-FF sync, 3 = strobe-qualified sync). It runs the synchronizer through every enabled mode: it drives sel, stb and pseudo-random test data, waits for the data to settle, then compares the synchronizer output against the data it drove. Mismatches are counted per mode and read back through a small readout port. It sits in the clk domain, between the chip-level control inputs and the synchronizer datapath.

---
 rtl/sync_seq_pkg.sv | 42 ++++
 rtl/sync_mode_sequencer_if.sv | 10 +
 rtl/sync_seq_lfsr8.sv | 36 +++
 rtl/sync_mode_sequencer.sv | 158 +++++++++++++++
 tb/tb_sync_mode_sequencer.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_seq_pkg.sv
// Shared types and constants for the synchronizer self-test sequencer.
package sync_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRIVE,
        ST_STROBE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } seq_state_e;

    // Synchronizer mode numbers as seen on sel[1:0]
    localparam logic [1:0] MODE_REG    = 2'd0;
    localparam logic [1:0] MODE_NOSYNC = 2'd1;
    localparam logic [1:0] MODE_2FF    = 2'd2;
    localparam logic [1:0] MODE_STB    = 2'd3;

    // Feedback taps d7^d5^d4^d3 and the value substituted for an all-zero seed
    localparam logic [7:0] LFSR_TAPS         = 8'hB8;
    localparam logic [7:0] LFSR_SEED_DEFAULT = 8'h01;

    typedef struct packed {
        logic       found;
        logic [1:0] mode;
    } mode_hit_t;

    // Lowest set mask bit at or above 'from'
    function automatic mode_hit_t find_mode(input logic [3:0] mask, input logic [2:0] from);
        mode_hit_t hit;
        hit = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!hit.found && mask[i] && (i >= {29'd0, from})) begin
                hit.found = 1'b1;
                hit.mode  = 2'(i);
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/sync_mode_sequencer_if.sv
// Sequencer <-> synchronizer datapath bundle.
interface sync_mode_sequencer_if;
    logic [2:0] sel;
    logic       stb;
    logic [7:0] test_data;
    logic [7:0] sync_data_in;

    modport master (output sel, stb, test_data, input sync_data_in);
    modport slave  (input sel, stb, test_data, output sync_data_in);
endinterface

// File: rtl/sync_seq_lfsr8.sv
// 8-bit Fibonacci LFSR with seed load (zero seed replaced) and step.
module sync_seq_lfsr8
    import sync_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] seed_i,
    input  logic       step_i,
    output logic [7:0] data_o
);

    logic [7:0] lfsr_q, lfsr_d;

    // Load has priority over step; shift left with parity of tapped bits into bit 0
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = (seed_i == '0) ? LFSR_SEED_DEFAULT : seed_i;
        end else if (step_i) begin
            lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    // LFSR state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED_DEFAULT;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign data_o = lfsr_q;

endmodule

// File: rtl/sync_mode_sequencer.sv
// Self-test controller: steps the synchronizer through each enabled mode,
// drives LFSR data, waits for settling and counts mismatches per mode.
module sync_mode_sequencer
    import sync_seq_pkg::*;
#(
    parameter int unsigned NUM_VECTORS   = 16,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned STB_CYCLES    = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [3:0]            mode_mask,
    input  logic [7:0]            seed,
    input  logic [1:0]            rd_mode,
    sync_mode_sequencer_if.master sync_bus,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      err_cnt,
    output logic                  any_err
);

    localparam logic [7:0]       LAST_VEC    = 8'(NUM_VECTORS - 1);
    localparam logic [15:0]      STB_LAST    = 16'(STB_CYCLES - 1);
    localparam logic [15:0]      SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    seq_state_e       state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [7:0]       data_q, data_d;
    logic [3:0]       mask_q, mask_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [7:0]       vec_q, vec_d;
    logic [15:0]      wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic             lfsr_load, lfsr_step;
    logic [7:0]       lfsr_data;
    mode_hit_t        load_hit, next_hit;

    sync_seq_lfsr8 u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (lfsr_load),
        .seed_i (seed),
        .step_i (lfsr_step),
        .data_o (lfsr_data)
    );

    // Next-state, counter and datapath updates; abort overrides every busy state
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        data_d    = data_q;
        mask_d    = mask_q;
        ptr_d     = ptr_q;
        vec_d     = vec_q;
        wait_d    = wait_q;
        cnt_d     = cnt_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        load_hit  = find_mode(mask_q, ptr_q);
        next_hit  = find_mode(mask_q, {1'b0, mode_q} + 3'd1);

        if (state_q != ST_IDLE && abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        cnt_d     = '{default: '0};
                        lfsr_load = 1'b1;
                        mask_d    = mode_mask;
                        ptr_d     = '0;
                        state_d   = (mode_mask == '0) ? ST_DONE : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    mode_d  = load_hit.mode;
                    ptr_d   = {1'b0, load_hit.mode};
                    vec_d   = '0;
                    state_d = load_hit.found ? ST_DRIVE : ST_DONE;
                end
                ST_DRIVE: begin
                    data_d    = lfsr_data;
                    lfsr_step = 1'b1;
                    wait_d    = '0;
                    state_d   = (mode_q == MODE_STB) ? ST_STROBE : ST_SETTLE;
                end
                ST_STROBE: begin
                    if (wait_q == STB_LAST) begin
                        wait_d  = '0;
                        state_d = ST_SETTLE;
                    end else begin
                        wait_d = wait_q + 16'd1;
                    end
                end
                ST_SETTLE: begin
                    if (wait_q == SETTLE_LAST) begin
                        state_d = ST_CHECK;
                    end else begin
                        wait_d = wait_q + 16'd1;
                    end
                end
                ST_CHECK: begin
                    if (sync_bus.sync_data_in != data_q && cnt_q[mode_q] != CNT_MAX) begin
                        cnt_d[mode_q] = cnt_q[mode_q] + 1'b1;
                    end
                    if (vec_q < LAST_VEC) begin
                        vec_d   = vec_q + 8'd1;
                        state_d = ST_DRIVE;
                    end else if (next_hit.found) begin
                        ptr_d   = {1'b0, mode_q} + 3'd1;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_REG;
            data_q  <= '0;
            mask_q  <= '0;
            ptr_q   <= '0;
            vec_q   <= '0;
            wait_q  <= '0;
            cnt_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            ptr_q   <= ptr_d;
            vec_q   <= vec_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sync_bus.sel       = {1'b0, mode_q};
    assign sync_bus.stb       = (state_q == ST_STROBE);
    assign sync_bus.test_data = data_q;
    assign busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done    = (state_q == ST_DONE);
    assign err_cnt = cnt_q[rd_mode];
    assign any_err = (cnt_q[0] != '0) || (cnt_q[1] != '0) || (cnt_q[2] != '0) || (cnt_q[3] != '0);

endmodule

// File: tb/tb_sync_mode_sequencer.sv
// Scoreboard bench: a schedule model predicts per-cycle outputs, a monitor compares them.
module tb_sync_mode_sequencer;
    import sync_seq_pkg::*;

    localparam int unsigned NV = 16, SC = 4, SB = 2;
    localparam int unsigned S_NV = 200, S_SC = 1, S_SB = 3, S_CW = 4;
    localparam int unsigned K_LOAD = 0, K_DRIVE = 1, K_STB = 2, K_SETTLE = 3, K_CHECK = 4, K_DONE = 5, K_IDLE = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, abort, busy, done, any_err;
    logic [3:0] mode_mask;
    logic [7:0] seed, err_cnt;
    logic [1:0] rd_mode;
    logic       s_start, s_busy, s_done, s_any;
    logic [3:0] s_mask;
    logic [1:0] s_rd;
    logic [S_CW-1:0] s_err;

    sync_mode_sequencer_if sif ();
    sync_mode_sequencer_if sif_s ();

    sync_mode_sequencer #(.NUM_VECTORS(NV), .SETTLE_CYCLES(SC), .STB_CYCLES(SB), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode_mask(mode_mask), .seed(seed),
        .rd_mode(rd_mode), .sync_bus(sif), .busy(busy), .done(done), .err_cnt(err_cnt), .any_err(any_err));

    sync_mode_sequencer #(.NUM_VECTORS(S_NV), .SETTLE_CYCLES(S_SC), .STB_CYCLES(S_SB), .CNT_W(S_CW)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(1'b0), .mode_mask(s_mask), .seed(seed),
        .rd_mode(s_rd), .sync_bus(sif_s), .busy(s_busy), .done(s_done), .err_cnt(s_err), .any_err(s_any));

    // Synchronizer stand-in: 0 = loopback delayed one clk, 1 = stuck at zero, 2 = corrupt odd-parity-ends data
    int unsigned src;
    logic [7:0]  td_d1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) td_d1 <= 8'h00;
        else        td_d1 <= sif.test_data;
    end
    always_comb begin
        case (src)
            0:       sif.sync_data_in = td_d1;
            1:       sif.sync_data_in = 8'h00;
            default: sif.sync_data_in = td_d1 ^ ((td_d1[0] ^ td_d1[7]) ? 8'h10 : 8'h00);
        endcase
    end
    assign sif_s.sync_data_in = ~sif_s.test_data;

    typedef struct {
        int unsigned kind;
        int unsigned mode;
        int unsigned vec;
        logic busy, done, stb, sel_chk, td_chk, err;
        logic [2:0] sel;
        logic [7:0] td;
    } rec_t;

    rec_t        sched[$];
    rec_t        exp_q[$];
    int unsigned model_cnt[4];
    int unsigned total = 0, bad = 0;
    logic [3:0]  cur_mask;
    logic [7:0]  cur_seed;

    function automatic void chk(input string name, input int unsigned act, input int unsigned want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endfunction

    function automatic rec_t mk_rec(input int unsigned kind, input int unsigned m, input int unsigned v,
                                    input logic [7:0] td, input logic err);
        rec_t r;
        r.kind    = kind;
        r.mode    = m;
        r.vec     = v;
        r.busy    = (kind <= K_CHECK);
        r.done    = (kind == K_DONE);
        r.stb     = (kind == K_STB);
        r.sel_chk = (kind >= K_DRIVE) && (kind <= K_DONE) && (m < 4);
        r.td_chk  = (kind >= K_STB) && (kind <= K_DONE) && (m < 4);
        r.sel     = 3'(m);
        r.td      = td;
        r.err     = err;
        return r;
    endfunction

    function automatic logic mism(input logic [7:0] v, input int unsigned s);
        if (s == 0) return 1'b0;
        if (s == 1) return (v != 8'h00);
        return v[0] ^ v[7];
    endfunction

    // Reference schedule: every cycle from the start edge through one idle cycle after DONE
    function automatic void build_sched(input logic [3:0] mask, input logic [7:0] sd, input int unsigned s);
        logic [7:0]  l, lastv;
        int unsigned last;
        sched.delete();
        cur_mask = mask;
        cur_seed = sd;
        l     = (sd == 8'h00) ? 8'h01 : sd;
        lastv = 8'h00;
        last  = 4;
        for (int unsigned m = 0; m < 4; m++) begin
            if (mask[m]) begin
                sched.push_back(mk_rec(K_LOAD, 4, 0, 8'h00, 1'b0));
                for (int unsigned v = 0; v < NV; v++) begin
                    sched.push_back(mk_rec(K_DRIVE, m, v, 8'h00, 1'b0));
                    if (m == 3) for (int unsigned c = 0; c < SB; c++) sched.push_back(mk_rec(K_STB, m, v, l, 1'b0));
                    for (int unsigned c = 0; c < SC; c++) sched.push_back(mk_rec(K_SETTLE, m, v, l, 1'b0));
                    sched.push_back(mk_rec(K_CHECK, m, v, l, mism(l, s)));
                    lastv = l;
                    last  = m;
                    l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
                end
            end
        end
        sched.push_back(mk_rec(K_DONE, last, 0, lastv, 1'b0));
        sched.push_back(mk_rec(K_IDLE, 4, 0, 8'h00, 1'b0));
    endfunction

    function automatic int find_rec(input int unsigned kind, input int unsigned m, input int unsigned v);
        for (int i = 0; i < sched.size(); i++)
            if (sched[i].kind == kind && sched[i].mode == m && sched[i].vec == v) return i;
        return 1;
    endfunction

    // Monitor: one expected record per clk, sampled on the falling edge
    always @(negedge clk) begin : monitor
        rec_t e;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("busy", 32'(busy), 32'(e.busy));
            chk("done", 32'(done), 32'(e.done));
            chk("stb", 32'(sif.stb), 32'(e.stb));
            if (e.sel_chk) chk("sel", 32'(sif.sel), 32'(e.sel));
            if (e.td_chk) chk("test_data", 32'(sif.test_data), 32'(e.td));
        end
    end

    task automatic drain();
        int unsigned n = 0;
        while (exp_q.size() > 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d records left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_counters();
        logic anyv = 1'b0;
        for (int r = 0; r < 4; r++) begin
            rd_mode = 2'(r);
            #1;
            chk("err_cnt", 32'(err_cnt), model_cnt[r]);
            if (model_cnt[r] != 0) anyv = 1'b1;
        end
        chk("any_err", 32'(any_err), 32'(anyv));
        chk("busy_idle", 32'(busy), 0);
        chk("done_idle", 32'(done), 0);
    endtask

    // how: 0 = full run, 1 = abort during record cut, 2 = reset during record cut
    task automatic run_sched(input int cut, input int unsigned how);
        int n;
        n = (how == 0) ? sched.size() : cut + 1;
        for (int i = 0; i < 4; i++) model_cnt[i] = 0;
        for (int i = 0; i < n; i++)
            if (sched[i].kind == K_CHECK && sched[i].err && model_cnt[sched[i].mode] < 255) model_cnt[sched[i].mode]++;
        @(negedge clk);
        #1;
        mode_mask = cur_mask;
        seed      = cur_seed;
        start     = 1'b1;
        for (int i = 0; i < n; i++) exp_q.push_back(sched[i]);
        if (how == 1) repeat (2) exp_q.push_back(mk_rec(K_IDLE, 4, 0, 8'h00, 1'b0));
        @(posedge clk);
        #1;
        start     = 1'b0;
        mode_mask = 4'($urandom);
        seed      = 8'($urandom);
        if (how == 1) begin
            repeat (cut) @(posedge clk);
            #1 abort = 1'b1;
            @(posedge clk);
            #1 abort = 1'b0;
        end
        if (how == 2) begin
            repeat (cut) @(posedge clk);
            @(negedge clk);
            #1 rst_n = 1'b0;
            #1;
            chk("rst_stb", 32'(sif.stb), 0);
            chk("rst_sel", 32'(sif.sel), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_test_data", 32'(sif.test_data), 0);
            #1 rst_n = 1'b1;
            for (int i = 0; i < 4; i++) model_cnt[i] = 0;
        end
        drain();
        @(posedge clk);
        #1;
        check_counters();
    endtask

    initial begin
        int          idx, got;
        logic [3:0]  mk;
        logic [7:0]  sd;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode_mask = 4'h0; seed = 8'h00; rd_mode = 2'd0;
        s_start = 1'b0; s_mask = 4'h0; s_rd = 2'd0; src = 0;
        #13;
        chk("reset_sel", 32'(sif.sel), 0);
        chk("reset_stb", 32'(sif.stb), 0);
        chk("reset_test_data", 32'(sif.test_data), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_err_cnt", 32'(err_cnt), 0);
        chk("reset_any_err", 32'(any_err), 0);
        #10 rst_n = 1'b1;

        // Loopback, mode 0 only, seed A5: no errors, DONE 97 cycles after LOAD
        src = 0; build_sched(4'b0001, 8'hA5, 0); run_sched(0, 0);
        // Strobe mode only
        src = 2; build_sched(4'b1000, 8'h3C, 2); run_sched(0, 0);
        // Stuck-at-zero on modes 1 and 2 with zero seed
        src = 1; build_sched((4'b0001 << MODE_NOSYNC) | (4'b0001 << MODE_2FF), 8'h00, 1); run_sched(0, 0);

        // start together with abort in IDLE does nothing; counters keep previous values
        @(negedge clk);
        #1 start = 1'b1; abort = 1'b1; mode_mask = 4'b0001;
        repeat (3) exp_q.push_back(mk_rec(K_IDLE, 4, 0, 8'h00, 1'b0));
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        drain();
        @(posedge clk);
        #1 check_counters();

        // Abort in SETTLE of vector 5 in mode 2, then a new start clears the partial count
        src = 1; build_sched(4'b0100, 8'h5A, 1);
        idx = find_rec(K_SETTLE, 32'(MODE_2FF), 5);
        run_sched(idx, 1);
        src = 0; build_sched(4'b0001, 8'h11, 0); run_sched(0, 0);

        // Asynchronous reset during STROBE
        src = 2; build_sched(4'b1000, 8'hC3, 2);
        idx = find_rec(K_STB, 32'(MODE_STB), 2);
        run_sched(idx, 2);

        // Empty mask: DONE on the cycle after start, busy never set
        build_sched(4'b0000, 8'h77, 0); run_sched(0, 0);

        for (int n = 0; n < 6; n++) begin
            mk  = 4'($urandom_range(1, 15));
            sd  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            src = $urandom_range(0, 2);
            build_sched(mk, sd, src);
            if ($urandom_range(0, 2) == 0) begin
                idx = $urandom_range(1, sched.size() - 4);
                while (sched[idx].kind != K_SETTLE) idx++;
                run_sched(idx, 1);
            end else begin
                run_sched(0, 0);
            end
        end

        // Narrow counters with every vector mismatching: saturate at 15
        s_mask = 4'($urandom_range(1, 15));
        seed   = 8'($urandom);
        @(negedge clk);
        #1 s_start = 1'b1;
        @(posedge clk);
        #1 s_start = 1'b0;
        got = 0;
        for (int i = 0; i < 12000 && got == 0; i++) begin
            @(negedge clk);
            if (s_done) got = 1;
        end
        chk("sat_done_seen", 32'(got), 1);
        @(posedge clk);
        for (int r = 0; r < 4; r++) begin
            s_rd = 2'(r);
            #1;
            chk("sat_err_cnt", 32'(s_err), s_mask[r] ? 15 : 0);
        end
        chk("sat_any_err", 32'(s_any), 1);
        chk("sat_busy", 32'(s_busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
